// File: rtl/bin_dec_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin_dec_pkg;

   localparam int unsigned BIN_W = 10;
   localparam int unsigned DIG_W = 4;

   localparam logic [BIN_W-1:0] C_HUND = BIN_W'(100);
   localparam logic [BIN_W-1:0] C_TENS = BIN_W'(10);
   localparam logic [BIN_W-1:0] C_MAX  = BIN_W'(999);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HUND = 2'd1,
      TENS = 2'd2,
      FIN  = 2'd3
   } state_e;

endpackage

// File: rtl/bin_dec_step.sv
// Compare-and-subtract step shared by the hundreds and tens phases.
module bin_dec_step
   import bin_dec_pkg::*;
(
   input  logic [BIN_W-1:0] rem_i,
   input  logic             sel_hund_i,
   output logic             ge_c,
   output logic [BIN_W-1:0] diff_c
);

   logic [BIN_W-1:0] k_c;

   always_comb begin
      k_c    = sel_hund_i ? C_HUND : C_TENS;
      ge_c   = (rem_i >= k_c);
      diff_c = rem_i - k_c;
   end

endmodule

// File: rtl/bin_dec_seq.sv
// Sequential binary-to-BCD converter (repeated subtraction of 100 then 10).
// Optional input saturation at 999 with an overflow flag: BIN_DEC_SEQ_SAT_EN.
module bin_dec_seq
   import bin_dec_pkg::*;
(
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             START,
   input  logic [BIN_W-1:0] BIN_IN,
   output logic             BUSY,
   output logic             DONE,
   output logic [DIG_W-1:0] DEC_HUND,
   output logic [DIG_W-1:0] DEC_TENS,
   output logic [DIG_W-1:0] DEC_ONES,
   output logic             OVF
);

   state_e           state_q, state_d;
   logic [BIN_W-1:0] rem_q, rem_d;
   logic [DIG_W-1:0] hund_q, hund_d;
   logic [DIG_W-1:0] tens_q, tens_d;
   logic             ovf_pend_q, ovf_pend_d;
   logic [DIG_W-1:0] dec_hund_q, dec_hund_d;
   logic [DIG_W-1:0] dec_tens_q, dec_tens_d;
   logic [DIG_W-1:0] dec_ones_q, dec_ones_d;
   logic             ovf_q, ovf_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             sat_c;
   logic             ge_c;
   logic [BIN_W-1:0] diff_c;

   bin_dec_step u_step (
      .rem_i      (rem_q),
      .sel_hund_i (state_q == HUND),
      .ge_c       (ge_c),
      .diff_c     (diff_c)
   );

   always_comb begin
`ifdef BIN_DEC_SEQ_SAT_EN
      sat_c = (BIN_IN > C_MAX);
`else
      sat_c = 1'b0;
`endif
   end

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         state_q    <= IDLE;
         rem_q      <= '0;
         hund_q     <= '0;
         tens_q     <= '0;
         ovf_pend_q <= 1'b0;
         dec_hund_q <= '0;
         dec_tens_q <= '0;
         dec_ones_q <= '0;
         ovf_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         rem_q      <= rem_d;
         hund_q     <= hund_d;
         tens_q     <= tens_d;
         ovf_pend_q <= ovf_pend_d;
         dec_hund_q <= dec_hund_d;
         dec_tens_q <= dec_tens_d;
         dec_ones_q <= dec_ones_d;
         ovf_q      <= ovf_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   // Digits are published only on entry to FIN, so DONE and DEC_* change together.
   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      hund_d     = hund_q;
      tens_d     = tens_q;
      ovf_pend_d = ovf_pend_q;
      dec_hund_d = dec_hund_q;
      dec_tens_d = dec_tens_q;
      dec_ones_d = dec_ones_q;
      ovf_d      = ovf_q;
      done_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (START) begin
               rem_d      = sat_c ? C_MAX : BIN_IN;
               hund_d     = '0;
               tens_d     = '0;
               ovf_pend_d = sat_c;
               state_d    = HUND;
            end
         end
         HUND: begin
            if (ge_c) begin
               rem_d  = diff_c;
               hund_d = hund_q + DIG_W'(1);
            end else begin
               state_d = TENS;
            end
         end
         TENS: begin
            if (ge_c) begin
               rem_d  = diff_c;
               tens_d = tens_q + DIG_W'(1);
            end else begin
               dec_hund_d = hund_q;
               dec_tens_d = tens_q;
               dec_ones_d = rem_q[DIG_W-1:0];
               ovf_d      = ovf_pend_q;
               done_d     = 1'b1;
               state_d    = FIN;
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   assign BUSY     = busy_q;
   assign DONE     = done_q;
   assign DEC_HUND = dec_hund_q;
   assign DEC_TENS = dec_tens_q;
   assign DEC_ONES = dec_ones_q;
   assign OVF      = ovf_q;

endmodule

// File: tb/tb_bin_dec_seq.sv
// Directed self-checking bench for bin_dec_seq (latency, digits, START handling, reset abort, sweep).
module tb_bin_dec_seq;

   logic       CLK;
   logic       RESET_N;
   logic       START;
   logic [9:0] BIN_IN;
   logic       BUSY;
   logic       DONE;
   logic [3:0] DEC_HUND;
   logic [3:0] DEC_TENS;
   logic [3:0] DEC_ONES;
   logic       OVF;

   int n_checks;
   int n_fail;
   logic [11:0] prev_dig;
   logic        prev_ovf;

   bin_dec_seq dut (
      .CLK      (CLK),
      .RESET_N  (RESET_N),
      .START    (START),
      .BIN_IN   (BIN_IN),
      .BUSY     (BUSY),
      .DONE     (DONE),
      .DEC_HUND (DEC_HUND),
      .DEC_TENS (DEC_TENS),
      .DEC_ONES (DEC_ONES),
      .OVF      (OVF)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One conversion; inj > 0 pulses START (with BIN_IN=47) in cycle N+inj.
   task automatic convert(input logic [9:0] v, input int eh, input int et, input int eo,
                          input int eovf, input int lat, input int inj);
      logic seen;
      seen = 1'b0;
      @(negedge CLK);
      START  = 1'b1;
      BIN_IN = v;
      @(posedge CLK);
      #1;
      START  = 1'b0;
      BIN_IN = 10'd1023;
      for (int k = 1; k <= 40; k++) begin
         @(negedge CLK);
         if (k == inj) begin
            START  = 1'b1;
            BIN_IN = 10'd47;
         end else begin
            START = 1'b0;
         end
         chk("busy_during", 32'(BUSY), 32'd1);
         if (DONE) begin
            seen = 1'b1;
            chk("latency", 32'(k), 32'(lat));
            chk("digits", 32'({DEC_HUND, DEC_TENS, DEC_ONES}), 32'({4'(eh), 4'(et), 4'(eo)}));
            chk("ovf", 32'(OVF), 32'(eovf));
            break;
         end
         chk("dec_hold", 32'({DEC_HUND, DEC_TENS, DEC_ONES}), 32'(prev_dig));
         chk("ovf_hold", 32'(OVF), 32'(prev_ovf));
      end
      if (!seen) chk("done_timeout", 32'd0, 32'd1);
      @(negedge CLK);
      START = 1'b0;
      chk("done_pulse_width", 32'(DONE), 32'd0);
      chk("busy_idle", 32'(BUSY), 32'd0);
      @(negedge CLK);
      chk("no_queued_start", 32'(BUSY), 32'd0);
      chk("digits_held", 32'({DEC_HUND, DEC_TENS, DEC_ONES}), 32'({4'(eh), 4'(et), 4'(eo)}));
      prev_dig = {4'(eh), 4'(et), 4'(eo)};
      prev_ovf = 1'(eovf);
   endtask

   initial begin
      logic seen;
      int   eh, et, eo, eovf;
      n_checks = 0;
      n_fail   = 0;
      prev_dig = '0;
      prev_ovf = 1'b0;
      RESET_N  = 1'b0;
      START    = 1'b0;
      BIN_IN   = '0;

      // Reset state
      repeat (3) @(negedge CLK);
      chk("rst_busy", 32'(BUSY), 32'd0);
      chk("rst_done", 32'(DONE), 32'd0);
      chk("rst_ovf", 32'(OVF), 32'd0);
      chk("rst_digits", 32'({DEC_HUND, DEC_TENS, DEC_ONES}), 32'd0);
      RESET_N = 1'b1;
      @(negedge CLK);

      convert(10'd0,   0, 0, 0, 0, 3,  0);
      convert(10'd999, 9, 9, 9, 0, 21, 0);
      // Second START during the first conversion is dropped
      convert(10'd305, 3, 0, 5, 0, 6,  3);
      convert(10'd47,  0, 4, 7, 0, 7,  0);
      // START in the FIN cycle is dropped
      convert(10'd47,  0, 4, 7, 0, 7,  7);
`ifdef BIN_DEC_SEQ_SAT_EN
      convert(10'd1023, 9, 9, 9, 1, 21, 0);
`else
      convert(10'd1023, 10, 2, 3, 0, 15, 0);
`endif
      convert(10'd100, 1, 0, 0, 0, 4, 0);
      convert(10'd99,  0, 9, 9, 0, 12, 0);

      // Reset in HUND cycle 3 of 850 aborts with no DONE
      @(negedge CLK);
      START  = 1'b1;
      BIN_IN = 10'd850;
      @(posedge CLK);
      #1;
      START = 1'b0;
      repeat (3) @(negedge CLK);
      RESET_N = 1'b0;
      @(negedge CLK);
      RESET_N = 1'b1;
      chk("abort_busy", 32'(BUSY), 32'd0);
      chk("abort_ovf", 32'(OVF), 32'd0);
      chk("abort_digits", 32'({DEC_HUND, DEC_TENS, DEC_ONES}), 32'd0);
      seen = 1'b0;
      for (int k = 0; k < 25; k++) begin
         @(negedge CLK);
         if (DONE) seen = 1'b1;
      end
      chk("abort_no_done", 32'(seen), 32'd0);
      prev_dig = '0;
      prev_ovf = 1'b0;
      convert(10'd850, 8, 5, 0, 0, 16, 0);

      // Sweep with START held high
      @(negedge CLK);
      START  = 1'b1;
      BIN_IN = 10'd0;
      for (int v = 0; v < 1024; v++) begin
         @(posedge CLK);
`ifdef BIN_DEC_SEQ_SAT_EN
         if (v > 999) begin
            eh = 9; et = 9; eo = 9; eovf = 1;
         end else begin
            eh = v / 100; et = (v % 100) / 10; eo = v % 10; eovf = 0;
         end
`else
         eh = v / 100; et = (v % 100) / 10; eo = v % 10; eovf = 0;
`endif
         seen = 1'b0;
         for (int k = 1; k <= 40; k++) begin
            @(negedge CLK);
            if (DONE) begin
               seen = 1'b1;
               chk("sweep_latency", 32'(k), 32'(3 + eh + et));
               chk("sweep_digits", 32'({DEC_HUND, DEC_TENS, DEC_ONES}),
                   32'({4'(eh), 4'(et), 4'(eo)}));
               chk("sweep_ovf", 32'(OVF), 32'(eovf));
               break;
            end
         end
         if (!seen) begin
            chk("sweep_timeout", 32'd0, 32'd1);
            break;
         end
         if (v == 1023) START = 1'b0;
         else BIN_IN = 10'(v + 1);
         @(negedge CLK);
         chk("sweep_idle_gap", 32'(BUSY), 32'd0);
      end
      START = 1'b0;
      repeat (3) @(negedge CLK);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bin_dec_seq.md
BIN_DEC_SEQ -- requirements
Module: bin_dec_seq

Interface
REQ-001 SHALL have port CLK, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port RESET_N, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have port START, input, 1 bit: conversion request, sampled only in IDLE.
REQ-004 SHALL have port BIN_IN, input, 10 bits: unsigned binary value, captured in the cycle START is accepted.
REQ-005 SHALL have port BUSY, output, 1 bit: high whenever the state is not IDLE.
REQ-006 SHALL have port DONE, output, 1 bit: one-cycle pulse marking valid digit outputs.
REQ-007 SHALL have port DEC_HUND, output, 4 bits: BCD hundreds digit.
REQ-008 SHALL have port DEC_TENS, output, 4 bits: BCD tens digit.
REQ-009 SHALL have port DEC_ONES, output, 4 bits: BCD ones digit.
REQ-010 SHALL have port OVF, output, 1 bit: input-exceeded-999 flag (see Configuration).

Function
REQ-011 SHALL implement FSM states IDLE, HUND, TENS and FIN.
REQ-012 IDLE with START=1 SHALL load BIN_IN into a 10-bit remainder register, clear the digit counters and move to HUND; IDLE with START=0 SHALL stay in IDLE.
REQ-013 HUND SHALL, per cycle, subtract 100 from the remainder and increment the hundreds counter if remainder>=100; otherwise it SHALL move to TENS.
REQ-014 TENS SHALL, per cycle, subtract 10 from the remainder and increment the tens counter if remainder>=10; otherwise it SHALL copy remainder[3:0] to the ones digit and move to FIN.
REQ-015 FIN SHALL assert DONE for exactly one cycle, update DEC_HUND/DEC_TENS/DEC_ONES together in that cycle, and return to IDLE.
REQ-016 Accepting START in cycle N SHALL assert DONE in cycle N+3+h+t, where h and t are the hundreds and tens digits (value 0: N+3; value 999: N+21).
REQ-017 DEC_* outputs SHALL hold their last converted values until the next FIN, and SHALL NOT show intermediate counts.
REQ-018 START while BUSY=1 SHALL be ignored, with no queueing; START asserted in the FIN cycle SHALL also be ignored.
REQ-019 START held high continuously SHALL begin a new conversion on each return to IDLE, one idle cycle between DONE and the next BUSY.
REQ-020 All arithmetic SHALL be unsigned, and the remainder SHALL never underflow; the compare precedes the subtract within the same cycle.

Reset
REQ-021 RESET_N=0 at a rising edge SHALL force IDLE, BUSY=0, DONE=0, OVF=0, all DEC_* =0 and remainder/counters =0.
REQ-022 Reset asserted mid-conversion SHALL abort it with no DONE pulse; the first START after release SHALL convert normally.

Configuration
REQ-023 Macro BIN_DEC_SEQ_SAT_EN defined: BIN_IN>999 SHALL be clamped to 999 at load, and OVF SHALL be set at FIN and held with the digits until the next FIN.
REQ-024 Macro BIN_DEC_SEQ_SAT_EN undefined: OVF SHALL be constant 0, and inputs 1000-1023 SHALL yield DEC_HUND=4'd10 with correct tens/ones (DONE at N+3+10+t).

Structure
REQ-025 Shared package bin_dec_pkg SHALL hold the FSM state typedef and constants for 100, 10 and 999.
REQ-026 Compare-and-subtract SHALL be one sub-module, bin_dec_step, taking a 10-bit remainder and a constant select (100/10) and returning a ge flag and the difference; it is instantiated once and shared by HUND and TENS.

Verification
REQ-027 Reset, then START with BIN_IN=0 -> DONE at N+3, digits 0/0/0, OVF=0.
REQ-028 BIN_IN=999 -> DONE at N+21, digits 9/9/9, BUSY high N+1..N+21.
REQ-029 BIN_IN=305 then BIN_IN=47, the second START pulsed during the first conversion -> second START ignored, one DONE with 3/0/5; a later START gives 0/4/7.
REQ-030 BIN_IN=1023 -> with SAT_EN: 9/9/9 and OVF=1; without SAT_EN: 10/2/3 and OVF=0.
REQ-031 RESET_N low at HUND cycle 3 of BIN_IN=850 -> no DONE, all outputs 0; a following BIN_IN=850 yields 8/5/0.
REQ-032 Sweep 0..1023 with START held high -> every DONE matches the decimal digits of the input and the REQ-016 latency.
